// File: rtl/cpu_pkg.sv
// Shared definitions for the 3-stage processor front end.
// Used by fetch_sequencer and inst_decoder: state encoding, opcode
// constants and the opcode-legality helper.
package cpu_pkg;

    // Sequencer state encoding; TRAP is reachable only when
    // FETCH_SEQ_ILLEGAL_TRAP_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        TRAP   = 3'd4
    } state_t;

    // Opcodes live in ir[7:4]
    localparam logic [3:0] OP_LOAD      = 4'h0;
    localparam logic [3:0] OP_ADD       = 4'h1;
    localparam logic [3:0] OP_SUB       = 4'h2;
    localparam logic [3:0] OP_BITAND    = 4'h3;
    localparam logic [3:0] OP_INP       = 4'h4;
    localparam logic [3:0] OP_OUTP      = 4'h5;
    localparam logic [3:0] OP_MAX_LEGAL = 4'h5;

    // True when the opcode is one the decoder understands
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_MAX_LEGAL);
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: front stage of the 3-stage processor.
// Fetches the instruction byte at pc into ir, then produces one decode
// strobe (d) and a stall-extendable execute strobe (e) for inst_decoder,
// advancing pc once per completed instruction.
//
// Configuration macro: FETCH_SEQ_ILLEGAL_TRAP_EN
//   defined   -> adds output 'illegal' and a TRAP state entered from DECODE
//                when ir[7:4] > OP_MAX_LEGAL; TRAP holds until reset.
//   undefined -> every opcode goes through DECODE/EXEC.
//
// Handshakes:
//   memory  : mem_rd is high for the whole FETCH state with mem_addr=pc;
//             a rising edge with mem_ready=1 completes the read and captures
//             mem_rdata. mem_ready is ignored outside FETCH.
//   execute : ex_stall=1 at an EXEC edge keeps the FSM in EXEC with e high;
//             ex_stall is ignored outside EXEC.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    input  logic              ex_stall,
    output logic [7:0]        ir,
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    output logic              illegal,
`endif
    output logic              d,
    output logic              e,
    output logic [ADDR_W-1:0] pc,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t state;
    state_t state_next;
    logic   ir_load;
    logic   pc_inc;

    // State register: async reset discards any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the ir-load / pc-increment enables
    always_comb begin
        state_next = state;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // run is not looked at here: a started fetch always completes
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
                if (!op_is_legal(ir[7:4])) begin
                    state_next = TRAP;
                end else begin
                    state_next = EXEC;
                end
`else
                state_next = EXEC;
`endif
            end
            EXEC: begin
                // A stall outranks a stop request; run is sampled on the
                // first unstalled edge
                if (!ex_stall) begin
                    pc_inc     = 1'b1;
                    state_next = run ? FETCH : IDLE;
                end
            end
`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
            TRAP: begin
                state_next = TRAP;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Program counter: one increment per completed instruction, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RST;
        end else if (pc_inc) begin
            pc <= pc + PC_ONE;
        end
    end

    // Instruction register: changes only on a completed fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 8'h00;
        end else if (ir_load) begin
            ir <= mem_rdata;
        end
    end

    // Strobes decoded from the state register only, so d and e are exclusive
    assign mem_rd   = (state == FETCH);
    assign d        = (state == DECODE);
    assign e        = (state == EXEC);
    assign busy     = (state != IDLE);
    assign mem_addr = pc;

`ifdef FETCH_SEQ_ILLEGAL_TRAP_EN
    assign illegal  = (state == TRAP);
`endif

endmodule
